// File: rtl/dmem_responder.sv
// dmem_responder: single-port 32-bit data memory that answers one load/store
// request at a time after a fixed latency.
//
// Handshake: a request transfers on a rising CLK edge where REQ_V=1 and
// REQ_RDY=1 (RST low); a response transfers on an edge where RSP_V=1 and
// RSP_RDY=1. While RSP_V is high the response payload does not change.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit storage words (at most 16384)
//   LATENCY     : cycles from request acceptance to RSP_V high (1..15)
// Ports
//   CLK, RST    : clock, synchronous active-high reset
//   REQ_V/RDY   : request handshake
//   REQ_WE      : 1 = store, 0 = load
//   REQ_ADDR    : byte address
//   REQ_WDATA   : store data, used bytes right-aligned
//   REQ_SIZE    : 0 byte, 1 half, 2 word, 3 illegal
//   REQ_SIGNED  : sign-extend byte/half loads
//   RSP_V/RDY   : response handshake
//   RSP_RDATA   : load result (0 for stores and faults)
//   RSP_ERR     : faulting access
//   DBG_STATE   : current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_V,
  output logic        REQ_RDY,
  input  logic        REQ_WE,
  input  logic [15:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGNED,
  output logic        RSP_V,
  input  logic        RSP_RDY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  // Storage starts at zero and is never touched by reset.
  logic [31:0] mem [0:DEPTH_WORDS-1] = '{default: 32'h0};

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        cap_we;
  logic [15:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_size;
  logic        cap_signed;

  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // Transaction being completed: with LATENCY=1 RESP is entered on the
  // acceptance edge itself, before the capture registers hold the request.
  logic        t_we;
  logic [15:0] t_addr;
  logic [31:0] t_wdata;
  logic [1:0]  t_size;
  logic        t_signed;

  logic          accept;
  logic          enter_resp;
  logic          fault;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  assign REQ_RDY   = (state == S_IDLE);
  assign RSP_V     = (state == S_RESP);
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign DBG_STATE = state;

  assign accept     = (state == S_IDLE) && REQ_V;
  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

  assign t_we     = (state == S_IDLE) ? REQ_WE     : cap_we;
  assign t_addr   = (state == S_IDLE) ? REQ_ADDR   : cap_addr;
  assign t_wdata  = (state == S_IDLE) ? REQ_WDATA  : cap_wdata;
  assign t_size   = (state == S_IDLE) ? REQ_SIZE   : cap_size;
  assign t_signed = (state == S_IDLE) ? REQ_SIGNED : cap_signed;

  assign fault = (t_size == 2'd3) ||
                 ((t_size == 2'd1) && t_addr[0]) ||
                 ((t_size == 2'd2) && (t_addr[1:0] != 2'b00)) ||
                 (32'(t_addr[15:2]) >= 32'(DEPTH_WORDS));

  // Out-of-range addresses may alias here; fault gating discards the result.
  assign word_idx = t_addr[AW+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    rd_byte = 8'h00;
    case (t_addr[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = 8'h00;
    endcase
    rd_half = t_addr[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_val = 32'h0;
    case (t_size)
      2'd0: load_val = {{24{t_signed & rd_byte[7]}}, rd_byte};
      2'd1: load_val = {{16{t_signed & rd_half[15]}}, rd_half};
      2'd2: load_val = rd_word;
      default: load_val = 32'h0;
    endcase
  end

  // Store lanes: replicate the right-aligned data across lanes and let the
  // byte enables pick the target ones.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = 32'h0;
    case (t_size)
      2'd0: begin
        wr_be   = 4'b0001 << t_addr[1:0];
        wr_data = {4{t_wdata[7:0]}};
      end
      2'd1: begin
        wr_be   = t_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{t_wdata[15:0]}};
      end
      2'd2: begin
        wr_be   = 4'b1111;
        wr_data = t_wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = 32'h0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (REQ_V) begin
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (RSP_RDY) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_we     <= REQ_WE;
        cap_addr   <= REQ_ADDR;
        cap_wdata  <= REQ_WDATA;
        cap_size   <= REQ_SIZE;
        cap_signed <= REQ_SIGNED;
      end
      if (enter_resp) begin
        rsp_err_q   <= fault;
        rsp_rdata_q <= (fault || t_we) ? 32'h0 : load_val;
      end
    end
  end

  // The store commits on the same edge that enters RESP, so a reset in WAIT
  // aborts it while a reset in RESP leaves it in place.
  always_ff @(posedge CLK) begin
    if (!RST && enter_resp && t_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_V = 1'b0;
  logic        REQ_RDY;
  logic        REQ_WE = 1'b0;
  logic [15:0] REQ_ADDR = 16'h0;
  logic [31:0] REQ_WDATA = 32'h0;
  logic [1:0]  REQ_SIZE = 2'd0;
  logic        REQ_SIGNED = 1'b0;
  logic        RSP_V;
  logic        RSP_RDY = 1'b0;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [1:0]  DBG_STATE;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_V     (REQ_V),
    .REQ_RDY   (REQ_RDY),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .REQ_SIZE  (REQ_SIZE),
    .REQ_SIGNED(REQ_SIGNED),
    .RSP_V     (RSP_V),
    .RSP_RDY   (RSP_RDY),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .DBG_STATE (DBG_STATE)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Driver: present one request in IDLE; returns just after the acceptance edge
  // with the request bus scrambled so later stages must rely on captured values.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg, input string tag);
    @(negedge CLK);
    chk({tag, "_req_rdy"}, 32'(REQ_RDY), 32'd1);
    REQ_V      = 1'b1;
    REQ_WE     = we;
    REQ_ADDR   = addr;
    REQ_WDATA  = wd;
    REQ_SIZE   = sz;
    REQ_SIGNED = sg;
    @(posedge CLK);
    #1;
    REQ_V      = 1'b0;
    REQ_WE     = 1'b1;
    REQ_ADDR   = 16'hFFFF;
    REQ_WDATA  = 32'hFFFF_FFFF;
    REQ_SIZE   = 2'd3;
    REQ_SIGNED = 1'b1;
  endtask

  // Counts falling edges after acceptance until RSP_V; ends on that edge.
  task automatic wait_rsp(input string tag);
    int k;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (RSP_V === 1'b1) begin
        k = i;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(k), 32'(LATENCY));
  endtask

  task automatic finish_rsp(input string tag);
    RSP_RDY = 1'b1;
    @(posedge CLK);
    #1;
    RSP_RDY = 1'b0;
    @(negedge CLK);
    chk({tag, "_rsp_v_drop"}, 32'(RSP_V), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(REQ_RDY), 32'd1);
  endtask

  task automatic txn(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [1:0] sz, input logic sg,
                     input logic [31:0] exp_data, input logic exp_err, input string tag);
    issue(we, addr, wd, sz, sg, tag);
    wait_rsp(tag);
    chk({tag, "_rdata"}, RSP_RDATA, exp_data);
    chk({tag, "_err"}, 32'(RSP_ERR), 32'(exp_err));
    finish_rsp(tag);
  endtask

  initial begin
    int seen;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_rdy", 32'(REQ_RDY), 32'd1);
    chk("rst_rsp_v", 32'(RSP_V), 32'd0);
    chk("rst_rdata", RSP_RDATA, 32'h0);
    chk("rst_err", 32'(RSP_ERR), 32'd0);
    chk("rst_state", 32'(DBG_STATE), 32'd0);
    RST = 1'b0;

    // Word store / load
    txn(1'b1, 16'h0010, 32'h1234_5678, 2'd2, 1'b0, 32'h0, 1'b0, "st_w10");
    txn(1'b0, 16'h0010, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 1'b0, "ld_w10");

    // Byte store with junk in the unused upper bits, signed/unsigned reload
    txn(1'b1, 16'h0013, 32'hDEAD_BE80, 2'd0, 1'b0, 32'h0, 1'b0, "st_b13");
    txn(1'b0, 16'h0013, 32'h0, 2'd0, 1'b1, 32'hFFFF_FF80, 1'b0, "ld_b13_s");
    txn(1'b0, 16'h0013, 32'h0, 2'd0, 1'b0, 32'h0000_0080, 1'b0, "ld_b13_u");
    txn(1'b0, 16'h0010, 32'h0, 2'd2, 1'b1, 32'h8034_5678, 1'b0, "ld_w10_b");
    txn(1'b0, 16'h0011, 32'h0, 2'd0, 1'b1, 32'h0000_0056, 1'b0, "ld_b11_s");

    // Faults: misaligned half, misaligned word store, illegal size
    txn(1'b0, 16'h0011, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1, "ld_h11_err");
    txn(1'b1, 16'h0012, 32'hFFFF_FFFF, 2'd2, 1'b0, 32'h0, 1'b1, "st_w12_err");
    txn(1'b0, 16'h0010, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1, "ld_sz3_err");
    txn(1'b1, 16'h0010, 32'hFFFF_FFFF, 2'd3, 1'b0, 32'h0, 1'b1, "st_sz3_err");
    txn(1'b0, 16'h0010, 32'h0, 2'd2, 1'b0, 32'h8034_5678, 1'b0, "ld_w10_kept");

    // Depth boundary
    txn(1'b0, 16'h1000, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, "ld_w1000_err");
    txn(1'b1, 16'h0FFC, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 1'b0, "st_wffc");
    txn(1'b0, 16'h0FFC, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, "ld_wffc");

    // Half-word lanes
    txn(1'b1, 16'h0016, 32'h1234_BEEF, 2'd1, 1'b0, 32'h0, 1'b0, "st_h16");
    txn(1'b0, 16'h0016, 32'h0, 2'd1, 1'b1, 32'hFFFF_BEEF, 1'b0, "ld_h16_s");
    txn(1'b0, 16'h0016, 32'h0, 2'd1, 1'b0, 32'h0000_BEEF, 1'b0, "ld_h16_u");
    txn(1'b0, 16'h0014, 32'h0, 2'd2, 1'b0, 32'hBEEF_0000, 1'b0, "ld_w14");

    // Back-pressure: RSP_RDY low 5 cycles while a competing store is offered
    issue(1'b0, 16'h0010, 32'h0, 2'd2, 1'b0, "stall");
    wait_rsp("stall");
    REQ_V     = 1'b1;
    REQ_WE    = 1'b1;
    REQ_ADDR  = 16'h0010;
    REQ_WDATA = 32'h0;
    REQ_SIZE  = 2'd2;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_v", 32'(RSP_V), 32'd1);
      chk("stall_rdata", RSP_RDATA, 32'h8034_5678);
      chk("stall_req_rdy", 32'(REQ_RDY), 32'd0);
      @(negedge CLK);
    end
    REQ_V = 1'b0;
    finish_rsp("stall");
    txn(1'b0, 16'h0010, 32'h0, 2'd2, 1'b0, 32'h8034_5678, 1'b0, "ld_w10_nostore");

    // Reset while waiting aborts the store
    issue(1'b1, 16'h0020, 32'hAAAA_5555, 2'd2, 1'b0, "rst_wait");
    @(negedge CLK);
    chk("rst_wait_state", 32'(DBG_STATE), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (RSP_V !== 1'b0) seen++;
    end
    chk("rst_wait_no_rsp", 32'(seen), 32'd0);
    chk("rst_wait_req_rdy", 32'(REQ_RDY), 32'd1);
    txn(1'b0, 16'h0020, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, "ld_w20");

    // Reset during an error response clears it; reset after a store commits keeps data
    issue(1'b0, 16'h0021, 32'h0, 2'd2, 1'b0, "rst_resp_err");
    wait_rsp("rst_resp_err");
    chk("rst_resp_err_flag", 32'(RSP_ERR), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_resp_err_rsp_v", 32'(RSP_V), 32'd0);
    chk("rst_resp_err_cleared", 32'(RSP_ERR), 32'd0);

    issue(1'b1, 16'h0024, 32'h1122_3344, 2'd2, 1'b0, "rst_resp");
    wait_rsp("rst_resp");
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_resp_rsp_v", 32'(RSP_V), 32'd0);
    chk("rst_resp_req_rdy", 32'(REQ_RDY), 32'd1);
    txn(1'b0, 16'h0024, 32'h0, 2'd2, 1'b0, 32'h1122_3344, 1'b0, "ld_w24");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 1..15, giving the cycles from request acceptance to response valid.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit, with synchronous active-high reset.
REQ-005 The block SHALL have port REQ_V, input, 1 bit, request valid.
REQ-006 The block SHALL have port REQ_RDY, output, 1 bit, request ready.
REQ-007 The block SHALL have port REQ_WE, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port REQ_ADDR, input, 16 bits, byte address.
REQ-009 The block SHALL have port REQ_WDATA, input, 32 bits, store data; the used bytes are right-aligned.
REQ-010 The block SHALL have port REQ_SIZE, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-011 The block SHALL have port REQ_SIGNED, input, 1 bit, selecting sign extension on loads.
REQ-012 The block SHALL have port RSP_V, output, 1 bit, response valid.
REQ-013 The block SHALL have port RSP_RDY, input, 1 bit, response accepted by the initiator.
REQ-014 The block SHALL have port RSP_RDATA, output, 32 bits, load result.
REQ-015 The block SHALL have port RSP_ERR, output, 1 bit, flagging a faulting access.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, WAIT and RESP; REQ_RDY = 1 only in IDLE.
REQ-017 Acceptance SHALL occur on an edge where REQ_V=1, REQ_RDY=1 and RST=0. On that edge the block SHALL capture WE, ADDR, WDATA, SIZE and SIGNED.
REQ-018 On acceptance, the next state SHALL be RESP if LATENCY=1; otherwise it SHALL be WAIT with the wait counter loaded to LATENCY-2.
REQ-019 In WAIT, the counter SHALL decrement each cycle. When the counter is 0, the next state SHALL be RESP.
REQ-020 As a result, RSP_V SHALL first be high exactly LATENCY cycles after the acceptance edge.
REQ-021 In RESP, RSP_V = 1 and RSP_RDATA/RSP_ERR SHALL be held stable until the edge with RSP_RDY=1, after which the state SHALL be IDLE.
REQ-022 There SHALL be no same-cycle IDLE bypass, so the minimum request-to-request period is LATENCY+1 cycles.
REQ-023 The fault condition SHALL be any of: SIZE=3; SIZE=1 with ADDR[0]=1; SIZE=2 with ADDR[1:0]!=0; word index ADDR[15:2] >= DEPTH_WORDS.
REQ-024 On a fault, RSP_ERR = 1, RSP_RDATA = 0, and memory SHALL NOT be modified.
REQ-025 A legal store SHALL write little-endian byte lanes on the edge entering RESP.
REQ-026 For a byte store, WDATA[7:0] SHALL be written to lane ADDR[1:0].
REQ-027 For a half store, WDATA[15:0] SHALL be written to lanes ADDR[1]*2 and ADDR[1]*2+1.
REQ-028 For a word store, all 4 lanes SHALL be written.
REQ-029 A store response SHALL have RSP_RDATA = 0 and RSP_ERR = 0.
REQ-030 A legal load SHALL extract the addressed byte or half, then zero-extend it (SIGNED=0) or sign-extend it (SIGNED=1) to 32 bits. A word load ignores SIGNED.
REQ-031 Load data SHALL reflect memory contents as of the edge entering RESP; a load never observes a store that is still pending.
REQ-032 REQ_* inputs SHALL be ignored outside IDLE, and RSP_RDY SHALL be ignored outside RESP.
REQ-033 Storage SHALL be zero at simulation start.

Reset
REQ-034 While RST=1 at an edge, the state SHALL become IDLE, RSP_V = 0, RSP_ERR = 0, RSP_RDATA = 0, the counter = 0 and REQ_RDY = 1 the next cycle; no request is accepted on that edge.
REQ-035 Reset during WAIT SHALL abort the transaction with no memory write and no response.
REQ-036 Reset during RESP SHALL drop the response; a write already committed on entering RESP SHALL persist.
REQ-037 Reset SHALL NOT clear storage contents.

Verification
REQ-038 Bench SHALL cover: LATENCY=2, store word 0x12345678 to 0x0010, then load word from 0x0010 -> RSP_V high 2 cycles after each acceptance; load RSP_RDATA = 0x12345678, RSP_ERR = 0.
REQ-039 Bench SHALL cover: after REQ-038, store byte 0x80 to 0x0013, then load byte signed and unsigned from 0x0013 -> 0xFFFFFF80 and 0x00000080; word at 0x0010 reads 0x80345678.
REQ-040 Bench SHALL cover: load half from 0x0011, store word to 0x0012, and SIZE=3 -> RSP_ERR = 1, RSP_RDATA = 0, and word 0x0010 unchanged.
REQ-041 Bench SHALL cover: DEPTH_WORDS=1024, load word from 0x1000 -> RSP_ERR = 1.
REQ-042 Bench SHALL cover: RSP_RDY held low 5 cycles in RESP -> RSP_V/RSP_RDATA stable for all 5 cycles, REQ_RDY = 0; IDLE the cycle after RSP_RDY=1.
REQ-043 Bench SHALL cover: store 0xAAAA5555 to 0x0020 with RST pulsed 1 cycle in WAIT -> no RSP_V, REQ_RDY = 1 after reset, and word 0x0020 still reads its prior value 0x00000000.
